// File: rtl/add_sub_pipe_if.sv
// Handshake and operand/result bus for add_sub_pipe: valid/ready on both sides.
// master drives operands and out_ready; slave is the arithmetic unit.
interface add_sub_pipe_if #(
    parameter int LEN   = 16,
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic                  sat;
    logic [LANES*LEN-1:0]  in1;
    logic [LANES*LEN-1:0]  in2;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*LEN-1:0]  out_data;
    logic [LANES-1:0]      out_ovf;

    modport master (
        output in_valid, op, sat, in1, in2, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, op, sat, in1, in2, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Multi-lane signed add/sub/rsub/pass with optional saturation; 2-cycle latency, 1/cycle throughput.
// Two-entry pipeline (S1 operands, S2 results); out_ready low holds S2 and in_ready drops once S1 is also full.
module add_sub_pipe #(
    parameter int LEN   = 16,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              reset,
    add_sub_pipe_if.slave     bus,
    input  logic              clr_sticky,
    output logic [LANES-1:0]  sticky_ovf
);
    typedef struct packed {
        logic [1:0]           op;
        logic                 sat;
        logic [LANES*LEN-1:0] in1;
        logic [LANES*LEN-1:0] in2;
    } s1_t;

    s1_t                  s1_q;
    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s2_adv;
    logic [LANES*LEN-1:0] res;
    logic [LANES-1:0]     ovf;
    logic [LANES*LEN-1:0] out_data_q;
    logic [LANES-1:0]     out_ovf_q;
    logic [LEN:0]         a_ext;
    logic [LEN:0]         b_ext;
    logic [LEN:0]         r_ext;

    assign s2_adv        = !s2_valid || bus.out_ready;
    assign bus.in_ready  = !s1_valid || s2_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    // One extra bit per lane: overflow is exactly when the top two bits disagree.
    always_comb begin
        res   = '0;
        ovf   = '0;
        a_ext = '0;
        b_ext = '0;
        r_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext = {s1_q.in1[i*LEN+LEN-1], s1_q.in1[i*LEN +: LEN]};
            b_ext = {s1_q.in2[i*LEN+LEN-1], s1_q.in2[i*LEN +: LEN]};
            case (s1_q.op)
                2'b00:   r_ext = a_ext + b_ext;
                2'b01:   r_ext = a_ext - b_ext;
                2'b10:   r_ext = b_ext - a_ext;
                default: r_ext = a_ext;
            endcase
            ovf[i] = r_ext[LEN] ^ r_ext[LEN-1];
            if (s1_q.sat && ovf[i]) begin
                res[i*LEN +: LEN] = r_ext[LEN] ? {1'b1, {(LEN-1){1'b0}}}
                                               : {1'b0, {(LEN-1){1'b1}}};
            end else begin
                res[i*LEN +: LEN] = r_ext[LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            s2_valid   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= '0;
            sticky_ovf <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= '{op: bus.op, sat: bus.sat, in1: bus.in1, in2: bus.in2};
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= res;
                    out_ovf_q  <= ovf;
                end
            end
            // A lane setting in the same cycle as a clear keeps its flag.
            sticky_ovf <= (clr_sticky ? '0 : sticky_ovf)
                        | ((s2_adv && s1_valid) ? ovf : '0);
        end
    end
endmodule
